// File: rtl/rijndael_pkg.sv
// Shared constants and helpers for the iterative Rijndael encryptor:
// S-box ROM, round constants, GF(2^8) arithmetic, round count, ShiftRows offsets.
package rijndael_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_KEYEXP,
    S_ROUND,
    S_DONE
  } state_e;

  // Forward S-box, indexed by the input byte.
  localparam logic [7:0] SBOX_ROM [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round constants x^(i-1) in GF(2^8); entry 0 is never used. Index 29 is the
  // largest needed (NB=8, NK=4 expands 120 words).
  localparam logic [7:0] RCON_ROM [31] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36,
    8'h6c, 8'hd8, 8'hab, 8'h4d, 8'h9a, 8'h2f, 8'h5e, 8'hbc, 8'h63, 8'hc6,
    8'h97, 8'h35, 8'h6a, 8'hd4, 8'hb3, 8'h7d, 8'hfa, 8'hef, 8'hc5, 8'h91
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_ROM[b];
  endfunction

  function automatic logic [7:0] rcon(input logic [4:0] idx);
    return RCON_ROM[idx];
  endfunction

  // Multiply by x modulo the Rijndael polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  // One MixColumns column; row 0 sits in the most significant byte.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ gf_mul3(a1) ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ gf_mul3(a2) ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ gf_mul3(a3),
            gf_mul3(a0) ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic int nr(input int nb, input int nk);
    return ((nb > nk) ? nb : nk) + 6;
  endfunction

  // Left-rotation applied to a state row by ShiftRows for a given block width.
  function automatic int shift_offset(input int nb, input int row);
    case (row)
      1:       return 1;
      2:       return (nb == 8) ? 3 : 2;
      3:       return (nb >= 7) ? 4 : 3;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/rijndael_sbox.sv
// Combinational Rijndael byte substitution (forward S-box lookup).
module rijndael_sbox
  import rijndael_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // Single ROM lookup, no state.
  always_comb begin
    out_o = sbox(in_i);
  end

endmodule

// File: rtl/rijndael_encrypt.sv
// Iterative Rijndael encryptor: expands the whole key schedule one word per
// cycle, then performs one full round per cycle on a column-major state.
module rijndael_encrypt
  import rijndael_pkg::*;
#(
  parameter int NB = 4,
  parameter int NK = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  output logic              ready_o,
  output logic              valid_o,
  input  logic [32*NB-1:0]  plaintext_i,
  input  logic [32*NK-1:0]  key_i,
  output logic [32*NB-1:0]  ciphertext_o
);

  localparam int NR    = nr(NB, NK);
  localparam int NW    = NB * (NR + 1);
  localparam int IDX_W = $clog2(NW);
  localparam int BLK_W = 32 * NB;
  localparam int RND_W = 4;

  state_e             fsm_q, fsm_d;
  logic [BLK_W-1:0]   state_q, state_d;
  logic [BLK_W-1:0]   ct_q, ct_d;
  logic [31:0]        w_q [NW];
  logic [31:0]        w_d [NW];
  logic [IDX_W-1:0]   j_q, j_d;
  logic [2:0]         kmod_q, kmod_d;
  logic [4:0]         kdiv_q, kdiv_d;
  logic [RND_W-1:0]   round_q, round_d;

  logic               accept;
  logic [31:0]        prev_word, back_word, rot_word;
  logic [31:0]        sub_word_in, sub_word, key_tmp, new_word;
  logic [BLK_W-1:0]   sub_bytes, shifted, mixed, round_key, round_out;
  logic [IDX_W-1:0]   rk_base;

  assign accept = ((fsm_q == S_IDLE) || (fsm_q == S_DONE)) && enable_i;

  // SubWord lanes for the key schedule.
  for (genvar k = 0; k < 4; k++) begin : g_subword
    rijndael_sbox u_sbox_key (
      .in_i  (sub_word_in[8*k +: 8]),
      .out_o (sub_word[8*k +: 8])
    );
  end

  // SubBytes lanes, one per state byte.
  for (genvar i = 0; i < 4*NB; i++) begin : g_subbytes
    rijndael_sbox u_sbox_state (
      .in_i  (state_q[BLK_W-1-8*i -: 8]),
      .out_o (sub_bytes[BLK_W-1-8*i -: 8])
    );
  end

  // ShiftRows is pure wiring; MixColumns acts on each shifted column.
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SRC_C = (c + shift_offset(NB, r)) % NB;
      assign shifted[BLK_W-1-8*(4*c+r) -: 8] = sub_bytes[BLK_W-1-8*(4*SRC_C+r) -: 8];
    end
    assign mixed[BLK_W-1-32*c -: 32] = mix_column(shifted[BLK_W-1-32*c -: 32]);
  end

  // Next schedule word: w[j] = w[j-NK] ^ f(w[j-1]), f chosen by j mod NK.
  always_comb begin
    prev_word   = w_q[j_q - IDX_W'(1)];
    back_word   = w_q[j_q - IDX_W'(NK)];
    rot_word    = {prev_word[23:0], prev_word[31:24]};
    sub_word_in = (kmod_q == 3'd0) ? rot_word : prev_word;
    if (kmod_q == 3'd0) begin
      key_tmp = sub_word ^ {rcon(kdiv_q), 24'h000000};
    end else if ((NK > 6) && (kmod_q == 3'd4)) begin
      key_tmp = sub_word;
    end else begin
      key_tmp = prev_word;
    end
    new_word = back_word ^ key_tmp;
  end

  // Round key for the current round plus the three round flavours.
  always_comb begin
    rk_base   = IDX_W'(round_q) * IDX_W'(NB);
    round_key = '0;
    for (int c = 0; c < NB; c++) begin
      round_key[BLK_W-1-32*c -: 32] = w_q[rk_base + IDX_W'(c)];
    end
    if (round_q == '0) begin
      round_out = state_q ^ round_key;
    end else if (round_q == RND_W'(NR)) begin
      round_out = shifted ^ round_key;
    end else begin
      round_out = mixed ^ round_key;
    end
  end

  // Datapath next-state: load on accept, grow the schedule, then run rounds.
  always_comb begin
    state_d = state_q;
    ct_d    = ct_q;
    w_d     = w_q;
    j_d     = j_q;
    kmod_d  = kmod_q;
    kdiv_d  = kdiv_q;
    round_d = round_q;
    case (fsm_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = plaintext_i;
          for (int k = 0; k < NK; k++) begin
            w_d[k] = key_i[32*NK-1-32*k -: 32];
          end
          j_d     = IDX_W'(NK);
          kmod_d  = 3'd0;
          kdiv_d  = 5'd1;
          round_d = '0;
        end
      end
      S_KEYEXP: begin
        w_d[j_q] = new_word;
        j_d      = j_q + IDX_W'(1);
        if (kmod_q == 3'(NK-1)) begin
          kmod_d = 3'd0;
          kdiv_d = kdiv_q + 5'd1;
        end else begin
          kmod_d = kmod_q + 3'd1;
        end
      end
      S_ROUND: begin
        state_d = round_out;
        round_d = round_q + RND_W'(1);
        if (round_q == RND_W'(NR)) begin
          ct_d = round_out;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears state, result and the whole schedule.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= '0;
      ct_q    <= '0;
      j_q     <= '0;
      kmod_q  <= '0;
      kdiv_q  <= '0;
      round_q <= '0;
      for (int k = 0; k < NW; k++) begin
        w_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      ct_q    <= ct_d;
      j_q     <= j_d;
      kmod_q  <= kmod_d;
      kdiv_q  <= kdiv_d;
      round_q <= round_d;
      w_q     <= w_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q <= S_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // FSM next state: key expansion ends at the last word, rounds end at NR.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE, S_DONE: if (enable_i) fsm_d = S_KEYEXP;
      S_KEYEXP:       if (j_q == IDX_W'(NW-1)) fsm_d = S_ROUND;
      S_ROUND:        if (round_q == RND_W'(NR)) fsm_d = S_DONE;
      default:        fsm_d = S_IDLE;
    endcase
  end

  // FSM outputs: ready in IDLE/DONE, valid only in DONE.
  always_comb begin
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (fsm_q)
      S_IDLE:  ready_o = 1'b1;
      S_DONE: begin
        ready_o = 1'b1;
        valid_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign ciphertext_o = ct_q;

endmodule

// File: tb/tb_rijndael_encrypt.sv
// Self-checking bench for rijndael_encrypt: three configurations (4/4, 4/8,
// 8/8) against known vectors and a behavioural byte-array cipher model.
module tb_rijndael_encrypt;

  logic clk = 1'b0;
  logic rst_n;

  logic         en44, rdy44, vld44;
  logic [127:0] pt44, key44, ct44;
  logic         en48, rdy48, vld48;
  logic [127:0] pt48, ct48;
  logic [255:0] key48;
  logic         en88, rdy88, vld88;
  logic [255:0] pt88, key88, ct88;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sbox_ref [256];

  always #5 clk = ~clk;

  rijndael_encrypt #(.NB(4), .NK(4)) u_dut44 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en44), .ready_o(rdy44), .valid_o(vld44),
    .plaintext_i(pt44), .key_i(key44), .ciphertext_o(ct44));

  rijndael_encrypt #(.NB(4), .NK(8)) u_dut48 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en48), .ready_o(rdy48), .valid_o(vld48),
    .plaintext_i(pt48), .key_i(key48), .ciphertext_o(ct48));

  rijndael_encrypt #(.NB(8), .NK(8)) u_dut88 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en88), .ready_o(rdy88), .valid_o(vld88),
    .plaintext_i(pt88), .key_i(key88), .ciphertext_o(ct88));

  // Shift-and-add multiplication in GF(2^8).
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    logic       hi;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      hi = x[7];
      x  = {x[6:0], 1'b0};
      if (hi) x = x ^ 8'h1b;
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h00;
    for (int x = 1; x < 256; x++) begin
      if (gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word_ref(input logic [31:0] x);
    return {sbox_ref[x[31:24]], sbox_ref[x[23:16]], sbox_ref[x[15:8]], sbox_ref[x[7:0]]};
  endfunction

  // Reference cipher on a 4 x nb byte matrix; key/pt/ct right-aligned in 256 bits.
  function automatic logic [255:0] ref_encrypt(input int nb, input int nk,
                                               input logic [255:0] key, input logic [255:0] pt);
    int          nrounds, nw;
    logic [31:0] w [120];
    logic [7:0]  s [4][8];
    logic [7:0]  o [4][8];
    logic [7:0]  mc [4];
    int          sh [4];
    logic [31:0] t;
    logic [7:0]  rc, acc;
    logic [255:0] ct;
    nrounds = ((nb > nk) ? nb : nk) + 6;
    nw      = nb * (nrounds + 1);
    sh[0] = 0; sh[1] = 1; sh[2] = (nb == 8) ? 3 : 2; sh[3] = (nb >= 7) ? 4 : 3;
    mc[0] = 8'h02; mc[1] = 8'h03; mc[2] = 8'h01; mc[3] = 8'h01;
    for (int j = 0; j < nk; j++) w[j] = key[32*nk-1-32*j -: 32];
    rc = 8'h01;
    for (int j = nk; j < nw; j++) begin
      t = w[j-1];
      if (j % nk == 0) begin
        t  = sub_word_ref({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && j % nk == 4) begin
        t = sub_word_ref(t);
      end
      w[j] = w[j-nk] ^ t;
    end
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[32*nb-1-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= nrounds; rnd++) begin
      for (int c = 0; c < nb; c++)
        for (int r = 0; r < 4; r++)
          o[r][c] = sbox_ref[s[r][(c + sh[r]) % nb]];
      for (int c = 0; c < nb; c++)
        for (int r = 0; r < 4; r++) begin
          if (rnd < nrounds) begin
            acc = 8'h00;
            for (int i = 0; i < 4; i++) acc = acc ^ gmul(o[i][c], mc[(i - r + 4) % 4]);
          end else begin
            acc = o[r][c];
          end
          s[r][c] = acc ^ w[rnd*nb+c][31-8*r -: 8];
        end
    end
    ct = '0;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        ct[32*nb-1-8*(4*c+r) -: 8] = s[r][c];
    return ct;
  endfunction

  function automatic int latency(input int nb, input int nk);
    int n;
    n = ((nb > nk) ? nb : nk) + 6;
    return nb * (n + 1) - nk + n + 1;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic get_rdy(input int sel);
    case (sel)
      0:       return rdy44;
      1:       return rdy48;
      default: return rdy88;
    endcase
  endfunction

  function automatic logic get_vld(input int sel);
    case (sel)
      0:       return vld44;
      1:       return vld48;
      default: return vld88;
    endcase
  endfunction

  function automatic logic [255:0] get_ct(input int sel);
    case (sel)
      0:       return 256'(ct44);
      1:       return 256'(ct48);
      default: return ct88;
    endcase
  endfunction

  task automatic set_inputs(input int sel, input logic en, input logic [255:0] key,
                            input logic [255:0] pt);
    case (sel)
      0: begin en44 = en; key44 = key[127:0]; pt44 = pt[127:0]; end
      1: begin en48 = en; key48 = key;        pt48 = pt[127:0]; end
      default: begin en88 = en; key88 = key; pt88 = pt; end
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input int sel, input string tag, input logic exp_rdy,
                             input logic exp_vld);
    checkOutput($sformatf("%s_ready%0d", tag, sel), 256'(get_rdy(sel)), 256'(exp_rdy));
    checkOutput($sformatf("%s_valid%0d", tag, sel), 256'(get_vld(sel)), 256'(exp_vld));
  endtask

  // Pulse enable for one accept edge, scramble inputs, then count cycles to
  // completion; optionally re-pulse enable with junk data while busy.
  task automatic applyStimulus(input int sel, input logic [255:0] key, input logic [255:0] pt,
                               input int poke_at, output int cycles, output logic [255:0] result);
    @(negedge clk);
    set_inputs(sel, 1'b1, key, pt);
    @(posedge clk);
    #1;
    set_inputs(sel, 1'b0, rand256(), rand256());
    check_flags(sel, "accept", 1'b0, 1'b0);
    cycles = 0;
    while (cycles < 400) begin
      @(posedge clk);
      cycles++;
      #1;
      if (get_vld(sel) && get_rdy(sel)) break;
      set_inputs(sel, (cycles == poke_at), rand256(), rand256());
    end
    set_inputs(sel, 1'b0, rand256(), rand256());
    result = get_ct(sel);
  endtask

  localparam logic [255:0] K128A = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] P128A = 256'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] C128A = 256'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] K128B = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] P128B = 256'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] C128B = 256'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] C256  = 256'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K88   = 256'h2b7e151628aed2a6abf7158809cf4f3c2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] P88   = 256'h3243f6a8885a308d313198a2e03707343243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] C88   = 256'h512b41370932f9be41a6fa2332ac4f63f016c06f0a3d5352ae3b7ede4acc343d;

  initial begin
    int           cyc;
    logic [255:0] res, k, p, exp_ct;

    for (int b = 0; b < 256; b++) sbox_ref[b] = sbox_calc(8'(b));

    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) set_inputs(s, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check_flags(s, "reset", 1'b1, 1'b0);
      checkOutput($sformatf("reset_ct%0d", s), get_ct(s), '0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] known-answer vectors");
    applyStimulus(0, K128A, P128A, 0, cyc, res);
    checkOutput("aes128_ct", res, C128A);
    checkOutput("aes128_lat", 256'(cyc), 256'd51);

    applyStimulus(0, K128B, P128B, 0, cyc, res);
    checkOutput("b2b_ct", res, C128B);
    checkOutput("b2b_lat", 256'(cyc), 256'd51);

    applyStimulus(1, K256, P128B, 0, cyc, res);
    checkOutput("aes256_ct", res, C256);
    checkOutput("aes256_lat", 256'(cyc), 256'(latency(4, 8)));

    applyStimulus(2, K88, P88, 0, cyc, res);
    checkOutput("r256_ct", res, C88);
    checkOutput("r256_lat", 256'(cyc), 256'd127);

    $display("[TB] busy protection");
    k = rand256();
    p = rand256();
    applyStimulus(0, k, p, 45, cyc, res);
    checkOutput("busy_ct", res, ref_encrypt(4, 4, k, p));
    checkOutput("busy_lat", 256'(cyc), 256'd51);

    $display("[TB] reset during key expansion");
    @(negedge clk);
    set_inputs(2, 1'b1, rand256(), rand256());
    @(posedge clk);
    #1;
    set_inputs(2, 1'b0, rand256(), rand256());
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_flags(2, "midrst", 1'b1, 1'b0);
    checkOutput("midrst_ct", get_ct(2), '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_flags(2, "postrst", 1'b1, 1'b0);
    applyStimulus(2, K88, P88, 0, cyc, res);
    checkOutput("rerun_ct", res, C88);
    checkOutput("rerun_lat", 256'(cyc), 256'd127);

    $display("[TB] random vectors");
    for (int s = 0; s < 3; s++) begin
      for (int n = 0; n < 3; n++) begin
        int nb, nk;
        nb = (s == 2) ? 8 : 4;
        nk = (s == 0) ? 4 : 8;
        k = rand256();
        p = rand256();
        exp_ct = ref_encrypt(nb, nk, k, p);
        applyStimulus(s, k, p, 0, cyc, res);
        checkOutput($sformatf("rand_ct%0d_%0d", s, n), res, exp_ct);
        checkOutput($sformatf("rand_lat%0d_%0d", s, n), 256'(cyc), 256'(latency(nb, nk)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
